uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
- Receive-side counterpart of the frame sender. Assembles a byte stream from the UART byte receiver into one FRAME_BYTES*8-bit frame and presents it to the consumer with a recv/recv_done handshake.
- This mirrors the send/send_done handshake used on the transmit path.
- Sits between the UART byte receiver and the application logic that consumes 320-bit frames.

Parameters:
- FRAME_BYTES, 40, bytes per frame; data width = FRAME_BYTES*8; legal range 1..255.
- TIMEOUT_CYCLES, 50000, maximum idle clk cycles between bytes inside a frame before the partial frame is discarded; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rx_valid  input  1  one-cycle strobe: rx_byte holds a new received byte.
- rx_byte  input  8  received byte, qualified by rx_valid.
- recv  output  1  a complete frame is held on data; stays high until acknowledged.
- data  output  FRAME_BYTES*8  last completed frame; byte k of the frame occupies bits [8k+7:8k], so the first byte received is at [7:0].
- recv_done  input  1  consumer acknowledge; sampled only while recv=1.
- overrun  output  1  one-cycle pulse: a byte was dropped because a frame was pending.
- timeout_err  output  1  one-cycle pulse: a partial frame was discarded after a gap.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at a clk edge, the block loads its reset values:
  - state=IDLE;
  - recv=0, data=0, overrun=0, timeout_err=0;
  - byte counter=0, gap timer=0, assembly register=0.
  - Reset mid-frame or mid-hold discards everything, with no error pulse.
- Registers: the assembly register (FRAME_BYTES*8) is internal. The data output register is updated only on frame completion, so data is stable whenever recv=1 and stays stable until the next completion.
- Widths: byte counter is $clog2(FRAME_BYTES+1) bits; gap timer is $clog2(TIMEOUT_CYCLES+1) bits; both are unsigned and saturating-free because they are always cleared before wrap.
- IDLE:
  - rx_valid=1: write rx_byte to assembly byte 0. If FRAME_BYTES=1, complete immediately (see completion). Otherwise set count=1, clear the timer and go to COLLECT.
- COLLECT:
  - rx_valid=1: write rx_byte to assembly byte [count] and clear the timer.
    - If count==FRAME_BYTES-1, complete. Otherwise count+1.
  - rx_valid=0: timer+1.
    - When the timer reaches TIMEOUT_CYCLES-1, the next cycle has timeout_err=1, state=IDLE and count=0. The assembly contents are don't-care. data and recv are untouched.
- Completion (on the edge that captures the last byte):
  - data <= assembly with the final byte merged.
  - recv <= 1, state <= HOLD.
  - Latency: recv and the new data are visible in the cycle after the last byte's rx_valid.
- HOLD:
  - recv=1 is held.
  - recv_done=1 and rx_valid=0: next cycle recv=0, state=IDLE.
  - recv_done=1 and rx_valid=1 in the same cycle: recv drops next cycle and the byte is accepted as byte 0 of a new frame (state=COLLECT, count=1). No overrun.
  - recv_done=0 and rx_valid=1: the byte is dropped and overrun=1 the next cycle. State remains HOLD.
  - There is no timeout in HOLD; the wait is unbounded.
- recv_done outside HOLD is ignored.
- overrun and timeout_err are registered single-cycle pulses. They can never be asserted in the same cycle.

Decomposition:
- Shared uart package:
  - state encoding: IDLE=2'd0, COLLECT=2'd1, HOLD=2'd2;
  - constant UART_FRAME_BYTES=40;
  - constant UART_TIMEOUT_CYCLES default.
  - The transmitter uses the same frame-width constant.
- The gap timer is a natural sub-module, uart_gap_timer. Its interface: clear, enable, limit parameter, expired pulse. Everything else stays in uart_frame_rx.

Test Plan:
- Basic frame (FRAME_BYTES=40): send bytes 0x00..0x27, one every 10 cycles, then pulse recv_done 3 cycles after recv rises.
  -> recv rises exactly 1 cycle after the 40th strobe; data[7:0]=0x00 and data[319:312]=0x27; recv falls 1 cycle after recv_done.
- Overrun: complete a frame with all bytes 0xAA, withhold recv_done, send byte 0x55.
  -> overrun pulses once; data is unchanged (all 0xAA); recv stays 1.
- Simultaneous ack and byte: in HOLD, assert recv_done together with rx_valid carrying 0x11, then send 39 more bytes of 0x22.
  -> no overrun; second frame has data[7:0]=0x11 and data[319:8] all 0x22.
- Timeout (TIMEOUT_CYCLES=100): send 5 bytes, then idle for 100 cycles.
  -> timeout_err pulses once, and the next 40 bytes form a complete frame starting with the 6th byte sent. A gap of 98 cycles produces no timeout.
- Reset mid-frame: send 20 bytes, then assert rst for 1 cycle.
  -> recv=0, data=0, no pulses; the next 40 bytes form a clean frame.
- FRAME_BYTES=1: single strobe with 0x7E.
  -> recv=1 next cycle with data=0x7E.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding and frame-size defaults.
package uart_pkg;

    localparam int unsigned UART_FRAME_BYTES    = 40;
    localparam int unsigned UART_TIMEOUT_CYCLES = 50000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } rx_state_e;

endpackage

// File: rtl/uart_gap_timer.sv
// Idle-gap counter. expired_c flags the enabled cycle that completes LIMIT idle cycles.
module uart_gap_timer #(
    parameter int unsigned LIMIT = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);

    localparam int unsigned TW = $clog2(LIMIT + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    assign expired_c = enable_i && (cnt_q == TW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = expired_c ? '0 : cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Assembles FRAME_BYTES received bytes into one frame and holds it on data
// under a recv/recv_done handshake; reports dropped bytes and inter-byte gaps.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int unsigned FRAME_BYTES    = UART_FRAME_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_byte,
    output logic                     recv,
    output logic [FRAME_BYTES*8-1:0] data,
    input  logic                     recv_done,
    output logic                     overrun,
    output logic                     timeout_err
);

    localparam int unsigned DW = FRAME_BYTES * 8;
    localparam int unsigned CW = $clog2(FRAME_BYTES + 1);

    rx_state_e        state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DW-1:0]    asm_q, asm_d;
    logic [DW-1:0]    data_q, data_d;
    logic             recv_q, recv_d;
    logic             overrun_q, overrun_d;
    logic             tmo_q, tmo_d;

    logic             accept_c;
    logic             last_c;
    logic [CW-1:0]    idx_c;
    logic [DW-1:0]    merged_c;
    logic             gap_clear_c;
    logic             gap_enable_c;
    logic             gap_expired_c;

    // A byte is taken when not holding a frame, or when it arrives with the ack.
    assign accept_c = rx_valid && ((state_q == IDLE) || (state_q == COLLECT) ||
                                   ((state_q == HOLD) && recv_done));
    assign idx_c    = (state_q == COLLECT) ? count_q : '0;
    assign last_c   = (idx_c == CW'(FRAME_BYTES - 1));

    always_comb begin
        merged_c = asm_q;
        for (int unsigned k = 0; k < FRAME_BYTES; k++) begin
            if (idx_c == CW'(k)) begin
                merged_c[8*k +: 8] = rx_byte;
            end
        end
    end

    assign gap_enable_c = (state_q == COLLECT) && !rx_valid;
    assign gap_clear_c  = !gap_enable_c;

    uart_gap_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (gap_clear_c),
        .enable_i  (gap_enable_c),
        .expired_c (gap_expired_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) state_d = last_c ? HOLD : COLLECT;
            end
            COLLECT: begin
                if (accept_c)           state_d = last_c ? HOLD : COLLECT;
                else if (gap_expired_c) state_d = IDLE;
            end
            HOLD: begin
                if (recv_done) begin
                    if (accept_c) state_d = last_c ? HOLD : COLLECT;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d   = count_q;
        asm_d     = asm_q;
        data_d    = data_q;
        recv_d    = recv_q;
        overrun_d = 1'b0;
        tmo_d     = 1'b0;
        if (accept_c) begin
            asm_d = merged_c;
            if (last_c) begin
                data_d  = merged_c;
                recv_d  = 1'b1;
                count_d = '0;
            end else begin
                recv_d  = 1'b0;
                count_d = idx_c + CW'(1);
            end
        end else if (state_q == HOLD) begin
            if (recv_done)     recv_d    = 1'b0;
            else if (rx_valid) overrun_d = 1'b1;
        end else if (gap_expired_c) begin
            tmo_d   = 1'b1;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            asm_q     <= '0;
            data_q    <= '0;
            recv_q    <= 1'b0;
            overrun_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            asm_q     <= asm_d;
            data_q    <= data_d;
            recv_q    <= recv_d;
            overrun_q <= overrun_d;
            tmo_q     <= tmo_d;
        end
    end

    assign recv        = recv_q;
    assign data        = data_q;
    assign overrun     = overrun_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboarded bench for uart_frame_rx: 40-byte instance plus a 1-byte instance.
module tb_uart_frame_rx;

    localparam int unsigned FB = 40;
    localparam int unsigned DW = FB * 8;
    localparam int KIND_REC = 0;
    localparam int KIND_OVR = 1;
    localparam int KIND_TMO = 2;

    typedef struct {
        int            kind;
        logic [DW-1:0] frame;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          recv_done;
    logic          recv;
    logic [DW-1:0] data;
    logic          overrun;
    logic          timeout_err;

    logic          rx_valid1;
    logic [7:0]    rx_byte1;
    logic          recv1;
    logic [7:0]    data1;
    logic          overrun1;
    logic          timeout_err1;

    int total = 0;
    int bad   = 0;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    uart_frame_rx #(.FRAME_BYTES(FB), .TIMEOUT_CYCLES(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .recv        (recv),
        .data        (data),
        .recv_done   (recv_done),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    uart_frame_rx #(.FRAME_BYTES(1), .TIMEOUT_CYCLES(100)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid1),
        .rx_byte     (rx_byte1),
        .recv        (recv1),
        .data        (data1),
        .recv_done   (1'b0),
        .overrun     (overrun1),
        .timeout_err (timeout_err1)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [DW-1:0] frame);
        ev_t e;
        e.kind  = kind;
        e.frame = frame;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk);
        recv_done = 1'b1;
        @(negedge clk);
        recv_done = 1'b0;
    endtask

    // Monitor: every recv rise or error pulse must match the next expected event.
    logic recv_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            recv_prev <= 1'b0;
        end else begin
            if (recv && !recv_prev) begin
                if (exp_q.size() == 0) chk("sb_unexpected_recv", 1, 0);
                else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("sb_kind_recv", DW'(e.kind), DW'(KIND_REC));
                    chk("sb_frame", data, e.frame);
                end
            end
            if (overrun) begin
                if (exp_q.size() == 0) chk("sb_unexpected_overrun", 1, 0);
                else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("sb_kind_overrun", DW'(e.kind), DW'(KIND_OVR));
                end
            end
            if (timeout_err) begin
                if (exp_q.size() == 0) chk("sb_unexpected_timeout", 1, 0);
                else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("sb_kind_timeout", DW'(e.kind), DW'(KIND_TMO));
                end
            end
            recv_prev <= recv;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] f;
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        recv_done = 1'b0;
        rx_valid1 = 1'b0;
        rx_byte1  = 8'h00;
        idle(3);
        rst = 1'b0;
        chk("reset_recv", DW'(recv), 0);
        chk("reset_data", data, '0);
        chk("reset_pulses", DW'({overrun, timeout_err}), 0);

        // Basic frame: bytes 0x00..0x27, one every 10 cycles.
        for (int k = 0; k < 40; k++) f[8*k +: 8] = 8'(k);
        push(KIND_REC, f);
        for (int k = 0; k < 40; k++) begin
            send_byte(8'(k));
            if (k == 38) chk("recv_early", DW'(recv), 0);
            if (k < 39) idle(9);
        end
        chk("recv_latency", DW'(recv), 1);
        chk("basic_lo", DW'(data[7:0]), DW'(8'h00));
        chk("basic_hi", DW'(data[319:312]), DW'(8'h27));
        idle(2);
        ack();
        chk("recv_fall", DW'(recv), 0);

        // Overrun: frame of 0xAA held, extra byte 0x55 dropped.
        push(KIND_REC, {40{8'hAA}});
        for (int k = 0; k < 40; k++) send_byte(8'hAA);
        push(KIND_OVR, '0);
        send_byte(8'h55);
        chk("overrun_data", data, {40{8'hAA}});
        chk("overrun_recv", DW'(recv), 1);
        idle(2);

        // Ack together with the first byte of the next frame.
        push(KIND_REC, {{39{8'h22}}, 8'h11});
        @(negedge clk);
        recv_done = 1'b1;
        rx_valid  = 1'b1;
        rx_byte   = 8'h11;
        @(negedge clk);
        recv_done = 1'b0;
        rx_valid  = 1'b0;
        chk("simul_recv_drop", DW'(recv), 0);
        for (int k = 0; k < 39; k++) send_byte(8'h22);
        chk("simul_recv", DW'(recv), 1);
        ack();

        // Timeout after 100 idle cycles; next 40 bytes form a fresh frame.
        for (int k = 0; k < 5; k++) send_byte(8'hE0 + 8'(k));
        push(KIND_TMO, '0);
        idle(100);
        for (int k = 0; k < 40; k++) f[8*k +: 8] = 8'h40 + 8'(k);
        push(KIND_REC, f);
        for (int k = 0; k < 40; k++) send_byte(8'h40 + 8'(k));
        chk("tmo_frame_first", DW'(data[7:0]), DW'(8'h40));
        ack();

        // A 98-cycle gap inside a frame is tolerated.
        for (int k = 0; k < 40; k++) f[8*k +: 8] = 8'h80 + 8'(k);
        push(KIND_REC, f);
        for (int k = 0; k < 40; k++) begin
            send_byte(8'h80 + 8'(k));
            if (k == 4) idle(98);
        end
        chk("gap98_recv", DW'(recv), 1);
        ack();

        // Reset mid-frame clears data and leaves no pulse.
        for (int k = 0; k < 20; k++) send_byte(8'h33);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_recv", DW'(recv), 0);
        chk("rst_mid_data", data, '0);
        for (int k = 0; k < 40; k++) f[8*k +: 8] = 8'hC0 ^ 8'(k);
        push(KIND_REC, f);
        for (int k = 0; k < 40; k++) send_byte(8'hC0 ^ 8'(k));
        chk("rst_mid_frame", DW'(recv), 1);
        ack();
        idle(3);

        // Single-byte frames complete on the first strobe.
        chk("fb1_idle", DW'(recv1), 0);
        @(negedge clk);
        rx_valid1 = 1'b1;
        rx_byte1  = 8'h7E;
        @(negedge clk);
        rx_valid1 = 1'b0;
        chk("fb1_recv", DW'(recv1), 1);
        chk("fb1_data", DW'(data1), DW'(8'h7E));
        chk("fb1_pulses", DW'({overrun1, timeout_err1}), 0);

        idle(5);
        chk("sb_drain", DW'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
